// File: rtl/host_jtag_pack.sv
// Byte-serial host to word-wide JTAG PHY bridge: packs host bytes into command words
// and unpacks response words into host bytes, each through its own FWFT word FIFO.
module host_jtag_pack #(
    parameter int unsigned JTAG_CMD_WIDTH  = 36,
    parameter int unsigned JTAG_RESP_WIDTH = 35,
    parameter int unsigned CMD_DEPTH       = 4,
    parameter int unsigned RESP_DEPTH      = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FLUSH,
    input  logic [7:0]                 HOST_WRDATA,
    input  logic                       HOST_WREN,
    output logic                       HOST_WRFULL,
    output logic [7:0]                 HOST_RDDATA,
    input  logic                       HOST_RDEN,
    output logic                       HOST_RDEMPTY,
    output logic                       HOST_PARTIAL,
    output logic [JTAG_CMD_WIDTH-1:0]  JTAG_CMD_RDDATA,
    input  logic                       JTAG_CMD_RDEN,
    output logic                       JTAG_CMD_RDEMPTY,
    input  logic [JTAG_RESP_WIDTH-1:0] JTAG_RESP_WRDATA,
    input  logic                       JTAG_RESP_WREN,
    output logic                       JTAG_RESP_WRFULL
);

    localparam int unsigned CMD_BYTES  = (JTAG_CMD_WIDTH + 7) / 8;
    localparam int unsigned RESP_BYTES = (JTAG_RESP_WIDTH + 7) / 8;
    localparam int unsigned CMD_ASM_W  = CMD_BYTES * 8;
    localparam int unsigned RESP_PAD_W = RESP_BYTES * 8;
    localparam int unsigned CIW        = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int unsigned RIW        = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
    localparam int unsigned CAW        = $clog2(CMD_DEPTH);
    localparam int unsigned RAW        = $clog2(RESP_DEPTH);
    localparam int unsigned CCW        = CAW + 1;
    localparam int unsigned RCW        = RAW + 1;

    // Command path state
    logic [CIW-1:0]            r_cmd_idx;
    logic [CMD_ASM_W-1:0]      r_cmd_asm;
    logic [JTAG_CMD_WIDTH-1:0] r_cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]            r_cmd_wp;
    logic [CAW-1:0]            r_cmd_rp;
    logic [CCW-1:0]            r_cmd_cnt;

    // Response path state
    logic [RIW-1:0]             r_resp_idx;
    logic [JTAG_RESP_WIDTH-1:0] r_resp_mem [RESP_DEPTH];
    logic [RAW-1:0]             r_resp_wp;
    logic [RAW-1:0]             r_resp_rp;
    logic [RCW-1:0]             r_resp_cnt;

    logic                      w_cmd_full;
    logic                      w_cmd_empty;
    logic                      w_byte_acc;
    logic                      w_cmd_last;
    logic                      w_cmd_push;
    logic                      w_cmd_pop;
    logic [CMD_ASM_W-1:0]      w_asm_next;
    logic [JTAG_CMD_WIDTH-1:0] w_cmd_word;

    logic                      w_resp_full;
    logic                      w_resp_empty;
    logic                      w_resp_push;
    logic                      w_rd_acc;
    logic                      w_resp_last;
    logic                      w_resp_pop;
    logic [RESP_PAD_W-1:0]     w_head_pad;
    logic [7:0]                w_rd_byte;

    assign w_cmd_full  = (r_cmd_cnt == CCW'(CMD_DEPTH));
    assign w_cmd_empty = (r_cmd_cnt == '0);
    assign w_byte_acc  = HOST_WREN & ~w_cmd_full;
    assign w_cmd_last  = (r_cmd_idx == CIW'(CMD_BYTES - 1));
    assign w_cmd_push  = w_byte_acc & w_cmd_last;
    assign w_cmd_pop   = JTAG_CMD_RDEN & ~w_cmd_empty;

    // Merge the incoming byte so the completing byte lands in the same FIFO write
    always_comb begin
        w_asm_next = r_cmd_asm;
        for (int unsigned b = 0; b < CMD_BYTES; b++) begin
            if (r_cmd_idx == CIW'(b)) begin
                w_asm_next[b*8 +: 8] = HOST_WRDATA;
            end
        end
    end

    assign w_cmd_word = w_asm_next[JTAG_CMD_WIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            r_cmd_idx <= '0;
            r_cmd_asm <= '0;
            r_cmd_wp  <= '0;
            r_cmd_rp  <= '0;
            r_cmd_cnt <= '0;
        end else begin
            if (w_byte_acc) begin
                r_cmd_idx <= w_cmd_last ? '0 : r_cmd_idx + CIW'(1);
                r_cmd_asm <= w_cmd_last ? '0 : w_asm_next;
            end
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CAW'(1);
            if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CAW'(1);
            if (w_cmd_push && !w_cmd_pop)      r_cmd_cnt <= r_cmd_cnt + CCW'(1);
            else if (!w_cmd_push && w_cmd_pop) r_cmd_cnt <= r_cmd_cnt - CCW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= w_cmd_word;
    end

    assign HOST_WRFULL      = w_cmd_full;
    assign HOST_PARTIAL     = (r_cmd_idx != '0);
    assign JTAG_CMD_RDEMPTY = w_cmd_empty;
    assign JTAG_CMD_RDDATA  = w_cmd_empty ? '0 : r_cmd_mem[r_cmd_rp];

    assign w_resp_full  = (r_resp_cnt == RCW'(RESP_DEPTH));
    assign w_resp_empty = (r_resp_cnt == '0);
    assign w_resp_push  = JTAG_RESP_WREN & ~w_resp_full;
    assign w_rd_acc     = HOST_RDEN & ~w_resp_empty;
    assign w_resp_last  = (r_resp_idx == RIW'(RESP_BYTES - 1));
    assign w_resp_pop   = w_rd_acc & w_resp_last;

    // Head word zero-padded to whole bytes, then byte j selected
    always_comb begin
        w_head_pad = RESP_PAD_W'(r_resp_mem[r_resp_rp]);
        w_rd_byte  = '0;
        for (int unsigned b = 0; b < RESP_BYTES; b++) begin
            if (r_resp_idx == RIW'(b)) begin
                w_rd_byte = w_head_pad[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            r_resp_idx <= '0;
            r_resp_wp  <= '0;
            r_resp_rp  <= '0;
            r_resp_cnt <= '0;
        end else begin
            if (w_rd_acc)    r_resp_idx <= w_resp_last ? '0 : r_resp_idx + RIW'(1);
            if (w_resp_push) r_resp_wp  <= r_resp_wp + RAW'(1);
            if (w_resp_pop)  r_resp_rp  <= r_resp_rp + RAW'(1);
            if (w_resp_push && !w_resp_pop)      r_resp_cnt <= r_resp_cnt + RCW'(1);
            else if (!w_resp_push && w_resp_pop) r_resp_cnt <= r_resp_cnt - RCW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_resp_push) r_resp_mem[r_resp_wp] <= JTAG_RESP_WRDATA;
    end

    assign HOST_RDEMPTY     = w_resp_empty;
    assign HOST_RDDATA      = w_resp_empty ? 8'h00 : w_rd_byte;
    assign JTAG_RESP_WRFULL = w_resp_full;

endmodule

// File: tb/tb_host_jtag_pack.sv
// Directed bench for host_jtag_pack with default parameters (36-bit commands, 35-bit responses, depth 4).
module tb_host_jtag_pack;

    logic        CLK;
    logic        RESET;
    logic        FLUSH;
    logic [7:0]  HOST_WRDATA;
    logic        HOST_WREN;
    logic        HOST_WRFULL;
    logic [7:0]  HOST_RDDATA;
    logic        HOST_RDEN;
    logic        HOST_RDEMPTY;
    logic        HOST_PARTIAL;
    logic [35:0] JTAG_CMD_RDDATA;
    logic        JTAG_CMD_RDEN;
    logic        JTAG_CMD_RDEMPTY;
    logic [34:0] JTAG_RESP_WRDATA;
    logic        JTAG_RESP_WREN;
    logic        JTAG_RESP_WRFULL;

    int n_vec = 0;
    int n_err = 0;

    host_jtag_pack dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .FLUSH            (FLUSH),
        .HOST_WRDATA      (HOST_WRDATA),
        .HOST_WREN        (HOST_WREN),
        .HOST_WRFULL      (HOST_WRFULL),
        .HOST_RDDATA      (HOST_RDDATA),
        .HOST_RDEN        (HOST_RDEN),
        .HOST_RDEMPTY     (HOST_RDEMPTY),
        .HOST_PARTIAL     (HOST_PARTIAL),
        .JTAG_CMD_RDDATA  (JTAG_CMD_RDDATA),
        .JTAG_CMD_RDEN    (JTAG_CMD_RDEN),
        .JTAG_CMD_RDEMPTY (JTAG_CMD_RDEMPTY),
        .JTAG_RESP_WRDATA (JTAG_RESP_WRDATA),
        .JTAG_RESP_WREN   (JTAG_RESP_WREN),
        .JTAG_RESP_WRFULL (JTAG_RESP_WRFULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        HOST_WREN   = 1'b1;
        HOST_WRDATA = b;
        tick();
        HOST_WREN   = 1'b0;
    endtask

    task automatic rd_byte();
        HOST_RDEN = 1'b1;
        tick();
        HOST_RDEN = 1'b0;
    endtask

    task automatic pop_cmd();
        JTAG_CMD_RDEN = 1'b1;
        tick();
        JTAG_CMD_RDEN = 1'b0;
    endtask

    task automatic push_resp(input logic [34:0] w);
        JTAG_RESP_WREN   = 1'b1;
        JTAG_RESP_WRDATA = w;
        tick();
        JTAG_RESP_WREN   = 1'b0;
    endtask

    logic [7:0]  bytes_a [5];
    logic [7:0]  resp_b  [5];
    logic [35:0] cmd_exp [5];
    logic [7:0]  fill_b  [4];

    initial begin
        bytes_a = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hF9};
        resp_b  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h05};
        cmd_exp = '{36'h4_0302_0100, 36'h4_1312_1110, 36'h4_2322_2120,
                    36'h4_3332_3130, 36'h4_4342_4140};
        fill_b  = '{8'h10, 8'h20, 8'h30, 8'h40};

        RESET = 1'b1; FLUSH = 1'b0;
        HOST_WRDATA = '0; HOST_WREN = 1'b0; HOST_RDEN = 1'b0;
        JTAG_CMD_RDEN = 1'b0; JTAG_RESP_WRDATA = '0; JTAG_RESP_WREN = 1'b0;
        tick(); tick();
        RESET = 1'b0;

        chk("rst_wrfull",   HOST_WRFULL,      0);
        chk("rst_rdempty",  HOST_RDEMPTY,     1);
        chk("rst_rddata",   HOST_RDDATA,      0);
        chk("rst_partial",  HOST_PARTIAL,     0);
        chk("rst_cmdempty", JTAG_CMD_RDEMPTY, 1);
        chk("rst_cmddata",  JTAG_CMD_RDDATA,  0);
        chk("rst_respfull", JTAG_RESP_WRFULL, 0);

        // Five-byte command assembly
        wr_byte(bytes_a[0]);
        chk("asm_partial1", HOST_PARTIAL, 1);
        chk("asm_empty1",   JTAG_CMD_RDEMPTY, 1);
        for (int i = 1; i < 5; i++) wr_byte(bytes_a[i]);
        chk("asm_partial5", HOST_PARTIAL, 0);
        chk("asm_nonempty", JTAG_CMD_RDEMPTY, 0);
        chk("asm_word",     JTAG_CMD_RDDATA, 36'h9_8765_4321);
        pop_cmd();
        chk("asm_pop_empty", JTAG_CMD_RDEMPTY, 1);
        chk("asm_pop_data",  JTAG_CMD_RDDATA, 0);
        pop_cmd();
        chk("cmd_pop_when_empty", JTAG_CMD_RDEMPTY, 1);

        // Response unpacking, zero-padded top byte
        push_resp(35'h5_1234_5678);
        chk("resp_nonempty", HOST_RDEMPTY, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("resp_byte%0d", i), HOST_RDDATA, resp_b[i]);
            rd_byte();
        end
        chk("resp_empty_after", HOST_RDEMPTY, 1);
        chk("resp_data_after",  HOST_RDDATA, 0);

        // Fill command FIFO across pointer wrap
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 5; b++) wr_byte(8'(k * 16 + b));
        chk("full_wrfull", HOST_WRFULL, 1);
        chk("full_head0",  JTAG_CMD_RDDATA, cmd_exp[0]);
        wr_byte(8'hAA);
        chk("full_aa_partial", HOST_PARTIAL, 0);
        chk("full_aa_wrfull",  HOST_WRFULL, 1);
        pop_cmd();
        chk("full_pop_wrfull", HOST_WRFULL, 0);
        for (int b = 0; b < 5; b++) wr_byte(8'(64 + b));
        chk("full_again", HOST_WRFULL, 1);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("wrap_head%0d", k), JTAG_CMD_RDDATA, cmd_exp[k]);
            pop_cmd();
        end
        chk("wrap_drained", JTAG_CMD_RDEMPTY, 1);

        // FLUSH beats a concurrent byte write and clears both paths
        JTAG_RESP_WREN = 1'b1; JTAG_RESP_WRDATA = 35'h0_0000_00FF;
        wr_byte(8'h11);
        JTAG_RESP_WREN = 1'b0;
        wr_byte(8'h22);
        chk("flush_pre_partial", HOST_PARTIAL, 1);
        chk("flush_pre_resp",    HOST_RDEMPTY, 0);
        FLUSH = 1'b1;
        wr_byte(8'h33);
        FLUSH = 1'b0;
        chk("flush_partial", HOST_PARTIAL, 0);
        chk("flush_cmdempty", JTAG_CMD_RDEMPTY, 1);
        chk("flush_rdempty", HOST_RDEMPTY, 1);
        for (int b = 1; b <= 5; b++) wr_byte(8'(b));
        chk("flush_clean_word", JTAG_CMD_RDDATA, 36'h5_0403_0201);
        pop_cmd();

        // RESET mid-word on the response side
        push_resp(35'h1_AABB_CCDD);
        chk("rst_mid_b0", HOST_RDDATA, 8'hDD);
        rd_byte();
        chk("rst_mid_b1", HOST_RDDATA, 8'hCC);
        rd_byte();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_mid_rdempty",  HOST_RDEMPTY, 1);
        chk("rst_mid_respfull", JTAG_RESP_WRFULL, 0);
        push_resp(35'h2_0000_00EE);
        chk("rst_mid_newb0", HOST_RDDATA, 8'hEE);
        for (int i = 0; i < 5; i++) rd_byte();
        chk("rst_mid_drained", HOST_RDEMPTY, 1);

        // Full response FIFO: blocked push, then push with final-byte pop
        for (int k = 0; k < 4; k++) push_resp(35'(fill_b[k]));
        chk("rf_full", JTAG_RESP_WRFULL, 1);
        push_resp(35'h7_FFFF_FFFF);
        chk("rf_full_drop", JTAG_RESP_WRFULL, 1);
        for (int i = 0; i < 4; i++) rd_byte();
        JTAG_RESP_WREN = 1'b1; JTAG_RESP_WRDATA = 35'h7_FFFF_FFFF;
        rd_byte();
        JTAG_RESP_WREN = 1'b0;
        chk("rf_simul_notfull", JTAG_RESP_WRFULL, 0);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("rf_head%0d", k), HOST_RDDATA, fill_b[k]);
            for (int i = 0; i < 5; i++) rd_byte();
        end
        chk("rf_drained", HOST_RDEMPTY, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/host_jtag_pack.md
HOST_JTAG_PACK -- requirements
Module: host_jtag_pack

Interface
REQ-001 SHALL have parameter JTAG_CMD_WIDTH, default 36, command word width in bits (legal 8..64).
REQ-002 SHALL have parameter JTAG_RESP_WIDTH, default 35, response word width in bits (legal 8..64).
REQ-003 SHALL have parameters CMD_DEPTH and RESP_DEPTH, default 4 each, word FIFO depths (power of 2, >=2).
REQ-004 SHALL have ports, clock and reset first, in this order:
  - CLK  in  1  single clock; all logic on rising edge.
  - RESET  in  1  reset; synchronous, active-high.
  - FLUSH  in  1  synchronous clear of all datapath state.
  - HOST_WRDATA  in  8  command byte from host.
  - HOST_WREN  in  1  push command byte.
  - HOST_WRFULL  out  1  command byte not accepted.
  - HOST_RDDATA  out  8  current response byte.
  - HOST_RDEN  in  1  pop response byte.
  - HOST_RDEMPTY  out  1  no response byte available.
  - HOST_PARTIAL  out  1  partial command assembled.
  - JTAG_CMD_RDDATA  out  JTAG_CMD_WIDTH  head command word.
  - JTAG_CMD_RDEN  in  1  pop command word.
  - JTAG_CMD_RDEMPTY  out  1  command FIFO empty.
  - JTAG_RESP_WRDATA  in  JTAG_RESP_WIDTH  response word from PHY.
  - JTAG_RESP_WREN  in  1  push response word.
  - JTAG_RESP_WRFULL  out  1  response FIFO full.

Function
REQ-005 SHALL define CMD_BYTES = ceil(JTAG_CMD_WIDTH/8) and RESP_BYTES = ceil(JTAG_RESP_WIDTH/8).
REQ-006 SHALL pack command bytes little-endian: byte index i fills bits [8i+7:8i]; last-byte bits beyond JTAG_CMD_WIDTH are discarded.
REQ-007 SHALL accept a host byte when HOST_WREN=1 and HOST_WRFULL=0; HOST_WREN with HOST_WRFULL=1 changes no state.
REQ-008 SHALL keep a byte index 0..CMD_BYTES-1; on acceptance of index CMD_BYTES-1 it writes the assembled word, including that byte, into the command FIFO in the same cycle and returns the index to 0.
REQ-009 SHALL drive HOST_WRFULL=1 exactly when the command FIFO holds CMD_DEPTH words (registered count).
REQ-010 SHALL drive HOST_PARTIAL=1 exactly when the byte index is non-zero.
REQ-011 SHALL make the command FIFO first-word-fall-through: JTAG_CMD_RDEMPTY falls, with JTAG_CMD_RDDATA valid, on the cycle after the last byte is accepted into an empty FIFO.
REQ-012 SHALL pop the command head on JTAG_CMD_RDEN=1 with JTAG_CMD_RDEMPTY=0; JTAG_CMD_RDEN while empty is ignored.
REQ-013 SHALL drive JTAG_CMD_RDDATA=0 while JTAG_CMD_RDEMPTY=1.
REQ-014 SHALL accept a response word on JTAG_RESP_WREN=1 with JTAG_RESP_WRFULL=0; JTAG_RESP_WREN while full is dropped with no state change.
REQ-015 SHALL drive JTAG_RESP_WRFULL=1 exactly when the response FIFO holds RESP_DEPTH words.
REQ-016 SHALL present response byte index j of the head word on HOST_RDDATA, zero-padding bits beyond JTAG_RESP_WIDTH, first-word-fall-through; HOST_RDEMPTY=1 and HOST_RDDATA=0 while the response FIFO is empty.
REQ-017 SHALL advance j on HOST_RDEN=1 with HOST_RDEMPTY=0; at j=RESP_BYTES-1 it pops the head word and returns j to 0; HOST_RDEN while empty is ignored.
REQ-018 SHALL handle simultaneous push and pop on either FIFO in one cycle with the count unchanged and both operations performed; a push while full is blocked even with a concurrent pop.
REQ-019 SHALL wrap FIFO pointers modulo depth with no data loss or duplication.
REQ-020 SHALL give FLUSH=1 priority over all concurrent pushes and pops in the same cycle, clearing FIFOs, byte indices and the assembler to reset state.
REQ-021 SHALL keep the command and response paths fully independent apart from FLUSH and RESET.

Reset
REQ-022 SHALL, on RESET=1 at a CLK edge, regardless of any operation in progress, drive: HOST_WRFULL=0, HOST_RDEMPTY=1, HOST_RDDATA=0, HOST_PARTIAL=0, JTAG_CMD_RDEMPTY=1, JTAG_CMD_RDDATA=0, JTAG_RESP_WRFULL=0; all counts, pointers and indices 0.
REQ-023 SHALL give RESET priority over FLUSH and all data operations.

Verification
REQ-024 Bytes 21,43,65,87,F9 on consecutive cycles -> HOST_PARTIAL 1 after first byte and 0 after fifth; JTAG_CMD_RDEMPTY=0 the following cycle; JTAG_CMD_RDDATA=36'h9_8765_4321.
REQ-025 Push response 35'h5_1234_5678 -> HOST_RDDATA reads 78,56,34,12,05 over five HOST_RDEN pops; HOST_RDEMPTY=1 after the fifth pop.
REQ-026 Four 5-byte commands with no pops -> HOST_WRFULL=1; a further byte AA is ignored (HOST_PARTIAL stays 0); one JTAG_CMD_RDEN -> HOST_WRFULL=0 the next cycle; FIFO order preserved across pointer wrap.
REQ-027 Two bytes written, then FLUSH=1 together with a HOST_WREN -> HOST_PARTIAL=0, the concurrent byte is dropped, and the next five bytes form a clean word.
REQ-028 Two response bytes read, then RESET -> HOST_RDEMPTY=1; JTAG_RESP_WRFULL=0; a new pushed word is read from byte 0.
REQ-029 Response FIFO full with simultaneous JTAG_RESP_WREN and final-byte HOST_RDEN -> pop occurs, push dropped, count = RESP_DEPTH-1.
